bin_to_ascii_tx: RTL and testbench
==================================

Name: bin_to_ascii_tx

Overview:
- Converts an NBIT-bit ALU result into its ASCII decimal string and pushes the characters, one per cycle, into the UART transmit FIFO.
- Sits between the ALU/control logic and the UART Tx FIFO.
- Generalises the 8-bit decimal-to-FIFO interface in four ways: parametrised width, optional signed (two's-complement) input, optional leading-zero suppression, and an optional CR/LF terminator.

Parameters:
- NBIT, 8, width of DATO_ALU.
- NDIG, 3, number of BCD digits; must be >= ceil(NBIT*log10(2)).
- SIGNED, 0, 1 = DATO_ALU is two's complement; a '-' is emitted for negative values.
- SUPPRESS_ZEROS, 1, 1 = leading zero digits are not sent; the units digit is always sent.
- APPEND_CRLF, 1, 1 = send 0x0D then 0x0A after the last digit.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- enviar  in  1  start request; sampled only in IDLE.
- fifo_full  in  1  Tx FIFO full flag.
- DATO_ALU  in  NBIT  value to print; latched when the start is accepted.
- WR_FIFO  out  1  FIFO write strobe; one character is written in each cycle it is high.
- data_fifo  out  8  ASCII character; valid when WR_FIFO=1, otherwise 0x00.
- busy  out  1  high from the cycle after the start is accepted through the last write cycle.
- done  out  1  one-cycle pulse in the cycle after the last write.

Behaviour:
- Reset: RESET=0 at a clock edge forces IDLE.
  - Clears magnitude, BCD, sign and digit-index registers.
  - busy=0, done=0, WR_FIFO=0, data_fifo=0x00.
  - Reset mid-conversion or mid-emission abandons the string; no further characters are written.
- States: IDLE, CONVERT, SIGN, DIGITS, CR, LF.
- IDLE, with enviar=1 at edge t:
  - Latch the magnitude: |DATO_ALU| if SIGNED=1 and the MSB is set, else DATO_ALU.
  - Latch neg = SIGNED & MSB.
  - Clear BCD and the shift counter; go to CONVERT.
  - Magnitude is held in NBIT bits unsigned, so the most negative value maps to 2^(NBIT-1) (-128 gives 128).
- CONVERT: double-dabble, one shift per cycle, NBIT cycles (t+1 .. t+NBIT).
  - Each cycle, add 3 to every BCD nibble >= 5, then shift {BCD, magnitude} left by 1.
  - After the last shift, go to SIGN if neg, else DIGITS.
  - During CONVERT, set the digit index to the most significant nonzero digit if SUPPRESS_ZEROS=1 (the units digit if all digits are zero), else to digit NDIG-1.
- Emission states (SIGN, DIGITS, CR, LF) send one character each:
  - WR_FIFO = state-is-emission & !fifo_full (combinational).
  - data_fifo = current character when WR_FIFO=1, else 0x00.
  - The state/index advances only in a cycle where WR_FIFO=1.
  - While fifo_full=1 the character is held; nothing is skipped, duplicated, or written.
- Characters:
  - SIGN: 0x2D.
  - DIGITS: 0x30 + digit, index decrementing down to 0.
  - CR: 0x0D.
  - LF: 0x0A.
  - After digit 0, go to CR if APPEND_CRLF=1, else to IDLE.
  - After LF, go to IDLE.
- Completion: on the edge of the last write, enter IDLE; done=1 for exactly that following cycle.
  - enviar=1 in the done cycle is accepted (back-to-back strings allowed).
- Timing:
  - First write is at cycle t+NBIT+1 when the FIFO is not full.
  - With no stalls, one character per cycle thereafter.
- enviar while busy is ignored (not queued). DATO_ALU changes after acceptance have no effect.
- No write is ever issued while fifo_full=1.

Test Plan:
- Defaults, DATO_ALU=0, enviar at t:
  - Writes 0x30, 0x0D, 0x0A at t+9, t+10, t+11.
  - done=1 at t+12; busy low at t+12.
- Defaults, DATO_ALU=255, no stalls:
  - Writes 0x32, 0x35, 0x35, 0x0D, 0x0A at t+9..t+13.
- SIGNED=1, DATO_ALU=8'h80:
  - Writes 0x2D, 0x31, 0x32, 0x38, 0x0D, 0x0A.
- SIGNED=1, DATO_ALU=8'hFF:
  - Writes 0x2D, 0x31, 0x0D, 0x0A.
- DATO_ALU=200, fifo_full=1 for 4 cycles starting at the second character:
  - WR_FIFO=0 during the stall.
  - Sequence is exactly 0x32, 0x30, 0x30, 0x0D, 0x0A; done is delayed by 4 cycles.
- SUPPRESS_ZEROS=0, APPEND_CRLF=0, DATO_ALU=7:
  - Writes 0x30, 0x30, 0x37.
  - Then, with NBIT=16 and NDIG=5, DATO_ALU=65535: writes 0x36, 0x35, 0x35, 0x33, 0x35, first at t+17.
- enviar pulsed again during CONVERT, and RESET=0 during DIGITS:
  - The second enviar is ignored.
  - After reset: no WR_FIFO, busy=0, done=0.
  - The next enviar produces a clean full string.

Source files
------------

// File: rtl/bin_to_ascii_tx.sv
// bin_to_ascii_tx: converts an NBIT-bit value to its ASCII decimal string
// (optional sign, optional leading-zero suppression, optional CR/LF) and
// writes it one character per cycle into a UART Tx FIFO, stalling on full.
module bin_to_ascii_tx #(
  parameter int NBIT           = 8,
  parameter int NDIG           = 3,
  parameter int SIGNED         = 0,
  parameter int SUPPRESS_ZEROS = 1,
  parameter int APPEND_CRLF    = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            enviar,
  input  logic            fifo_full,
  input  logic [NBIT-1:0] DATO_ALU,
  output logic            WR_FIFO,
  output logic [7:0]      data_fifo,
  output logic            busy,
  output logic            done
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(NBIT + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    SIGN    = 3'd2,
    DIGITS  = 3'd3,
    CR      = 3'd4,
    LF      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [NBIT-1:0] mag_q, mag_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_s;
  logic [7:0]      char_s;
  logic [3:0]      digit_s;
  logic            neg_in_s;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, mag} left.
  function automatic logic [BW+NBIT-1:0] dabble_step(input logic [BW-1:0] bcd,
                                                     input logic [NBIT-1:0] mag);
    logic [BW-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj[BW-2:0], mag, 1'b0};
  endfunction

  // Index of the most significant nonzero BCD digit; units digit when all are zero.
  function automatic logic [IW-1:0] msd_index(input logic [BW-1:0] bcd);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        r = IW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign digit_s  = bcd_q[{idx_q, 2'b00} +: 4];
  assign neg_in_s = (SIGNED != 0) && DATO_ALU[NBIT-1];

  // Next-state, datapath update and character selection.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_s    = 1'b0;
    char_s  = 8'h00;
    case (state_q)
      IDLE: begin
        if (enviar) begin
          neg_d   = neg_in_s;
          mag_d   = neg_in_s ? (~DATO_ALU + NBIT'(1)) : DATO_ALU;
          bcd_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        {bcd_d, mag_d} = dabble_step(bcd_q, mag_q);
        cnt_d          = cnt_q + CW'(1);
        idx_d          = (SUPPRESS_ZEROS != 0) ? msd_index(bcd_d) : IW'(NDIG - 1);
        if (cnt_q == CW'(NBIT - 1)) begin
          state_d = neg_q ? SIGN : DIGITS;
        end else begin
          state_d = CONVERT;
        end
      end
      SIGN: begin
        char_s = 8'h2D;
        wr_s   = !fifo_full;
        if (wr_s) begin
          state_d = DIGITS;
        end else begin
          state_d = SIGN;
        end
      end
      DIGITS: begin
        char_s = 8'h30 + {4'h0, digit_s};
        wr_s   = !fifo_full;
        if (wr_s && (idx_q == '0)) begin
          state_d = (APPEND_CRLF != 0) ? CR : IDLE;
          done_d  = (APPEND_CRLF == 0);
        end else if (wr_s) begin
          idx_d = idx_q - IW'(1);
        end else begin
          state_d = DIGITS;
        end
      end
      CR: begin
        char_s = 8'h0D;
        wr_s   = !fifo_full;
        if (wr_s) begin
          state_d = LF;
        end else begin
          state_d = CR;
        end
      end
      LF: begin
        char_s = 8'h0A;
        wr_s   = !fifo_full;
        if (wr_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = LF;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign WR_FIFO   = wr_s;
  assign data_fifo = wr_s ? char_s : 8'h00;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bin_to_ascii_tx.sv
// Testbench for bin_to_ascii_tx: four instances with different parameter
// sets run the same start/stall sequence; captured strings and timing are
// compared against a decimal-string reference model.
module tb_bin_to_ascii_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enviar = 1'b0;
  logic        fifo_full = 1'b0;
  logic [7:0]  d8 = 8'h00;
  logic [15:0] d16 = 16'h0000;
  logic        wr  [4];
  logic [7:0]  dat [4];
  logic        bz  [4];
  logic        dn  [4];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = -100;

  // Per-instance configuration used by the reference model.
  int nb [4] = '{8, 8, 8, 16};
  int nd [4] = '{3, 3, 3, 5};
  int sg [4] = '{0, 1, 0, 0};
  int sp [4] = '{1, 1, 0, 0};
  int cr [4] = '{1, 1, 0, 0};

  logic [7:0] got [4][8];
  int         got_n [4];
  logic [7:0] exp_s [4][8];
  int         exp_n [4];
  int         first_wr [4];
  int         last_wr [4];
  int         done_cnt [4];
  int         done_at [4];

  bin_to_ascii_tx #(.NBIT(8), .NDIG(3), .SIGNED(0), .SUPPRESS_ZEROS(1), .APPEND_CRLF(1)) u0 (
    .CLK(clk), .RESET(rst_n), .enviar(enviar), .fifo_full(fifo_full), .DATO_ALU(d8),
    .WR_FIFO(wr[0]), .data_fifo(dat[0]), .busy(bz[0]), .done(dn[0]));
  bin_to_ascii_tx #(.NBIT(8), .NDIG(3), .SIGNED(1), .SUPPRESS_ZEROS(1), .APPEND_CRLF(1)) u1 (
    .CLK(clk), .RESET(rst_n), .enviar(enviar), .fifo_full(fifo_full), .DATO_ALU(d8),
    .WR_FIFO(wr[1]), .data_fifo(dat[1]), .busy(bz[1]), .done(dn[1]));
  bin_to_ascii_tx #(.NBIT(8), .NDIG(3), .SIGNED(0), .SUPPRESS_ZEROS(0), .APPEND_CRLF(0)) u2 (
    .CLK(clk), .RESET(rst_n), .enviar(enviar), .fifo_full(fifo_full), .DATO_ALU(d8),
    .WR_FIFO(wr[2]), .data_fifo(dat[2]), .busy(bz[2]), .done(dn[2]));
  bin_to_ascii_tx #(.NBIT(16), .NDIG(5), .SIGNED(0), .SUPPRESS_ZEROS(0), .APPEND_CRLF(0)) u3 (
    .CLK(clk), .RESET(rst_n), .enviar(enviar), .fifo_full(fifo_full), .DATO_ALU(d16),
    .WR_FIFO(wr[3]), .data_fifo(dat[3]), .busy(bz[3]), .done(dn[3]));

  always #5 clk = ~clk;

  // Posedge counter; a value sampled at a negedge belongs to edge cyc+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Reference: decimal string from plain arithmetic on the value.
  task automatic build_exp(input int i, input int unsigned val);
    int unsigned m;
    int digs [8];
    int nsig;
    int n;
    bit neg;
    m = val;
    neg = 1'b0;
    if (sg[i] != 0 && val >= (32'd1 << (nb[i] - 1))) begin
      neg = 1'b1;
      m = (32'd1 << nb[i]) - val;
    end
    for (int k = 0; k < nd[i]; k++) begin
      digs[k] = int'(m % 10);
      m = m / 10;
    end
    nsig = nd[i];
    if (sp[i] != 0) begin
      nsig = 1;
      for (int k = 0; k < nd[i]; k++) if (digs[k] != 0) nsig = k + 1;
    end
    n = 0;
    if (neg) begin exp_s[i][n] = 8'h2D; n++; end
    for (int k = nsig - 1; k >= 0; k--) begin
      exp_s[i][n] = 8'(8'h30 + digs[k]);
      n++;
    end
    if (cr[i] != 0) begin
      exp_s[i][n] = 8'h0D; n++;
      exp_s[i][n] = 8'h0A; n++;
    end
    exp_n[i] = n;
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 4; i++) begin
      got_n[i] = 0; done_cnt[i] = 0; done_at[i] = -1;
      first_wr[i] = -1; last_wr[i] = -1;
    end
  endtask

  // Output monitor, sampling at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (fifo_full) chk($sformatf("wr_full%0d", i), {31'd0, wr[i]}, 32'd0);
        if (cyc == t_start) chk($sformatf("busy_start%0d", i), {31'd0, bz[i]}, 32'd1);
        if (wr[i]) begin
          if (got_n[i] < 8) got[i][got_n[i]] = dat[i];
          got_n[i]++;
          if (first_wr[i] < 0) first_wr[i] = cyc + 1;
          last_wr[i] = cyc + 1;
          chk($sformatf("busy_wr%0d", i), {31'd0, bz[i]}, 32'd1);
        end else begin
          chk($sformatf("dat_idle%0d", i), {24'd0, dat[i]}, 32'd0);
        end
        if (dn[i]) begin
          done_cnt[i]++;
          done_at[i] = cyc + 1;
          chk($sformatf("busy_done%0d", i), {31'd0, bz[i]}, 32'd0);
        end
      end
    end
  end

  function automatic bit all_done();
    return done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0 && done_cnt[3] > 0;
  endfunction

  // mode 0: no stall, 1: 4-cycle stall at second char, 2: random stall,
  // 3: no stall plus a second enviar during CONVERT.
  task automatic run(input logic [7:0] a, input logic [15:0] b, input int mode);
    int n;
    int lbl;
    @(posedge clk); #1;
    clear_caps();
    for (int i = 0; i < 3; i++) build_exp(i, {24'd0, a});
    build_exp(3, {16'd0, b});
    d8 = a; d16 = b; enviar = 1'b1; fifo_full = 1'b0;
    t_start = cyc + 1;
    @(posedge clk); #1;
    enviar = 1'b0;
    d8 = 8'($urandom); d16 = 16'($urandom);
    n = 0;
    while (!all_done() && n < 300) begin
      lbl = cyc + 1;
      case (mode)
        1: fifo_full = (lbl >= t_start + 10) && (lbl <= t_start + 13);
        2: fifo_full = ($urandom_range(0, 3) == 0);
        default: fifo_full = 1'b0;
      endcase
      enviar = (mode == 3) && (lbl == t_start + 3);
      @(posedge clk); #1;
      n++;
    end
    fifo_full = 1'b0; enviar = 1'b0;
    if (n >= 300) chk("timeout", 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("len%0d_v%0h", i, (i == 3) ? {16'd0, b} : {24'd0, a}), got_n[i], exp_n[i]);
      for (int k = 0; k < exp_n[i] && k < 8; k++)
        chk($sformatf("chr%0d_%0d", i, k), {24'd0, got[i][k]}, {24'd0, exp_s[i][k]});
      chk($sformatf("done_cnt%0d", i), done_cnt[i], 32'd1);
      chk($sformatf("done_at%0d", i), done_at[i], last_wr[i] + 1);
      if (mode == 0 || mode == 3) begin
        chk($sformatf("lat%0d", i), first_wr[i] - t_start, nb[i] + 1);
        chk($sformatf("done_lat%0d", i), done_at[i] - t_start, nb[i] + 1 + exp_n[i]);
      end else if (mode == 1) begin
        chk($sformatf("stall_done%0d", i), done_at[i] - t_start,
            nb[i] + 1 + exp_n[i] + ((i < 3) ? 4 : 0));
      end
    end
  endtask

  // Reset in the middle of emission (u0 in DIGITS, u3 still converting).
  task automatic reset_mid();
    @(posedge clk); #1;
    d8 = 8'd255; d16 = 16'd65535; enviar = 1'b1;
    t_start = cyc + 1;
    @(posedge clk); #1;
    enviar = 1'b0;
    while (cyc + 1 < t_start + 10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_caps();
    repeat (30) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rst_busy%0d", i), {31'd0, bz[i]}, 32'd0);
        chk($sformatf("rst_done%0d", i), {31'd0, dn[i]}, 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rst_nowr%0d", i), got_n[i], 32'd0);
  endtask

  initial begin
    clear_caps();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r_wr%0d", i), {31'd0, wr[i]}, 32'd0);
      chk($sformatf("r_dat%0d", i), {24'd0, dat[i]}, 32'd0);
      chk($sformatf("r_busy%0d", i), {31'd0, bz[i]}, 32'd0);
      chk($sformatf("r_done%0d", i), {31'd0, dn[i]}, 32'd0);
    end
    rst_n = 1'b1;
    run(8'd0, 16'd0, 0);
    run(8'd255, 16'd65535, 0);
    run(8'h80, 16'd10000, 0);
    run(8'hFF, 16'd0, 0);
    run(8'd200, 16'd1, 1);
    run(8'd7, 16'd9, 0);
    run(8'd100, 16'd100, 3);
    reset_mid();
    run(8'h7F, 16'd12345, 0);
    run(8'd10, 16'd99, 2);
    for (int r = 0; r < 25; r++)
      run(8'($urandom), 16'($urandom), ($urandom_range(0, 1) == 0) ? 0 : 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
